// File: rtl/register_set_init.sv
// Parametrised register file with grubby bit, optional zero register and write-to-read forwarding.
// A clear sequencer initialises every entry after reset so the array itself needs no reset.
module register_set_init #(
   parameter int               WIDTH      = 32,
   parameter int               ADDR_W     = 6,
   parameter int               ZERO_REG   = 1,
   parameter int               BYPASS     = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [WIDTH-1:0]  wd,
   input  logic              wg,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd1,
   output logic              rg1,
   output logic [WIDTH-1:0]  rd2,
   output logic              rg2,
   output logic              ready
);

   localparam int DEPTH = 2**ADDR_W;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   // Each entry is {grubby, data}
   logic [WIDTH:0]    mem [DEPTH];

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic [WIDTH:0]    rp1_q, rp1_d;
   logic [WIDTH:0]    rp2_q, rp2_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [WIDTH:0]    mem_wd;

   // Zero register masks everything, including a forwarded write to entry 0
   function automatic logic [WIDTH:0] read_port(
      input logic [ADDR_W-1:0] ra,
      input logic [WIDTH:0]    stored,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_addr,
      input logic [WIDTH:0]    wr_entry
   );
      logic [WIDTH:0] r;
      r = stored;
      if (ZERO_REG != 0 && ra == '0) begin
         r = '0;
      end else if (BYPASS != 0 && wr_en && wr_addr == ra) begin
         r = wr_entry;
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      rp1_d   = '0;
      rp2_d   = '0;
      mem_we  = 1'b0;
      mem_wa  = wa;
      mem_wd  = {wg, wd};
      if (state_q == ST_CLEAR) begin
         mem_we = 1'b1;
         mem_wa = cnt_q;
         mem_wd = {1'b0, INIT_VALUE};
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q == {ADDR_W{1'b1}}) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end
      end else begin
         mem_we = we;
         rp1_d  = read_port(ra1, mem[ra1], we, wa, {wg, wd});
         rp2_d  = read_port(ra2, mem[ra2], we, wa, {wg, wd});
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         rp1_q   <= '0;
         rp2_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         rp1_q   <= rp1_d;
         rp2_q   <= rp2_d;
      end
   end

   assign rd1   = rp1_q[WIDTH-1:0];
   assign rg1   = rp1_q[WIDTH];
   assign rd2   = rp2_q[WIDTH-1:0];
   assign rg2   = rp2_q[WIDTH];
   assign ready = ready_q;

endmodule

// File: tb/tb_register_set_init.sv
// Bench for register_set_init: a default instance (zero reg + bypass) and a plain instance
// (no zero reg, read-first) share all inputs and are checked against a behavioural model.
module tb_register_set_init;

   localparam int W     = 32;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic          clk  = 1'b0;
   logic          rstn = 1'b1;
   logic          we   = 1'b0;
   logic [AW-1:0] wa   = '0;
   logic [W-1:0]  wd   = '0;
   logic          wg   = 1'b0;
   logic [AW-1:0] ra1  = '0;
   logic [AW-1:0] ra2  = '0;

   logic [W-1:0]  rd1_a, rd2_a, rd1_b, rd2_b;
   logic          rg1_a, rg2_a, rg1_b, rg2_b, ready_a, ready_b;

   register_set_init dut_a (
      .clk(clk), .rstn(rstn), .we(we), .wa(wa), .wd(wd), .wg(wg),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rg1(rg1_a), .rd2(rd2_a), .rg2(rg2_a),
      .ready(ready_a)
   );

   register_set_init #(.ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rstn(rstn), .we(we), .wa(wa), .wd(wd), .wg(wg),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rg1(rg1_b), .rd2(rd2_b), .rg2(rg2_b),
      .ready(ready_b)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   // Model: the stored contents, whether the clear has finished, edges since release
   logic [W:0] mm [DEPTH];
   bit         model_run = 1'b0;
   int         edges     = 0;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [W-1:0]  wd;
      logic          wg;
      logic [AW-1:0] ra1;
      logic [AW-1:0] ra2;
      logic [W:0]    ea1;
      logic [W:0]    ea2;
      logic [W:0]    eb1;
      logic [W:0]    eb2;
   } vec_t;

   vec_t tbl [8];

   function automatic logic [W:0] predict(input bit zero, input bit byp, input logic [AW-1:0] ra);
      if (!model_run) return '0;
      if (zero && ra == '0) return '0;
      if (byp && we && wa == ra) return {wg, wd};
      return mm[ra];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      logic [W:0] pa1, pa2, pb1, pb2;
      pa1 = predict(1'b1, 1'b1, ra1);
      pa2 = predict(1'b1, 1'b1, ra2);
      pb1 = predict(1'b0, 1'b0, ra1);
      pb2 = predict(1'b0, 1'b0, ra2);
      if (model_run && we) mm[wa] = {wg, wd};
      @(posedge clk);
      edges++;
      if (!model_run && edges == DEPTH) begin
         model_run = 1'b1;
         for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      end
      #1;
      chk("ready_a", ready_a, model_run);
      chk("ready_b", ready_b, model_run);
      chk("a_port1", {rg1_a, rd1_a}, pa1);
      chk("a_port2", {rg2_a, rd2_a}, pa2);
      chk("b_port1", {rg1_b, rd1_b}, pb1);
      chk("b_port2", {rg2_b, rd2_b}, pb2);
   endtask

   // Asserts reset mid-cycle and checks the outputs drop without waiting for an edge
   task automatic do_reset();
      #2;
      rstn = 1'b0;
      #1;
      chk("rst_async_a", {ready_a, rg1_a, rd1_a, rg2_a, rd2_a}, 0);
      chk("rst_async_b", {ready_b, rg1_b, rd1_b, rg2_b, rd2_b}, 0);
      model_run = 1'b0;
      edges     = 0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic drive(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic g, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      we = w; wa = a; wd = d; wg = g; ra1 = r1; ra2 = r2;
   endtask

   initial begin
      tbl[0] = '{1'b1, 6'd9, 32'hAAAA0000, 1'b0, 6'd5, 6'd6, 33'h0, 33'h0, 33'h0, 33'h0};
      tbl[1] = '{1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 6'd9, 6'd9,
                 33'h0_AAAA0000, 33'h0_AAAA0000, 33'h0_AAAA0000, 33'h0_AAAA0000};
      tbl[2] = '{1'b0, 6'd0, 32'h0, 1'b0, 6'd5, 6'd6, 33'h1_DEADBEEF, 33'h0, 33'h1_DEADBEEF, 33'h0};
      tbl[3] = '{1'b1, 6'd9, 32'h12345678, 1'b0, 6'd9, 6'd9,
                 33'h0_12345678, 33'h0_12345678, 33'h0_AAAA0000, 33'h0_AAAA0000};
      tbl[4] = '{1'b0, 6'd0, 32'h0, 1'b0, 6'd9, 6'd9,
                 33'h0_12345678, 33'h0_12345678, 33'h0_12345678, 33'h0_12345678};
      tbl[5] = '{1'b1, 6'd0, 32'hFFFFFFFF, 1'b1, 6'd0, 6'd0, 33'h0, 33'h0, 33'h0, 33'h0};
      tbl[6] = '{1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 6'd9,
                 33'h0, 33'h0_12345678, 33'h1_FFFFFFFF, 33'h0_12345678};
      tbl[7] = '{1'b1, 6'd5, 32'h0, 1'b0, 6'd5, 6'd0,
                 33'h0, 33'h0, 33'h1_DEADBEEF, 33'h1_FFFFFFFF};

      do_reset();

      // Clear with writes attempted throughout, including the last CLEAR cycle
      for (int k = 0; k < DEPTH; k++) begin
         if (k < DEPTH - 1) drive(1'b1, 6'd10, 32'h55, 1'b1, 6'(k), 6'(63 - k));
         else               drive(1'b1, 6'd11, 32'h77, 1'b1, 6'(k), 6'(63 - k));
         step();
         if (k == DEPTH - 2) chk("ready_before_64", ready_a, 1'b0);
         if (k == DEPTH - 1) chk("ready_at_64", ready_a, 1'b1);
      end

      // Write in the cycle ready first rises is accepted
      drive(1'b1, 6'd12, 32'h12121212, 1'b1, 6'd0, 6'd0);
      step();

      for (int i = 1; i < DEPTH; i++) begin
         drive(1'b0, 6'd0, 32'h0, 1'b0, 6'(i), 6'((i + 1) % DEPTH));
         step();
      end
      drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd10, 6'd11);
      step();
      chk("clear_write_ignored", {rg1_a, rd1_a}, 33'h0);
      chk("last_clear_write_dropped", {rg2_a, rd2_a}, 33'h0);
      drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd12, 6'd3);
      step();
      chk("first_run_write", {rg1_b, rd1_b}, 33'h1_12121212);

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wg, tbl[i].ra1, tbl[i].ra2);
         step();
         chk($sformatf("tbl%0d_a1", i), {rg1_a, rd1_a}, tbl[i].ea1);
         chk($sformatf("tbl%0d_a2", i), {rg2_a, rd2_a}, tbl[i].ea2);
         chk($sformatf("tbl%0d_b1", i), {rg1_b, rd1_b}, tbl[i].eb1);
         chk($sformatf("tbl%0d_b2", i), {rg2_b, rd2_b}, tbl[i].eb2);
      end

      // Random traffic on a narrow address range so collisions are frequent
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
         step();
      end

      // Reset in RUN with non-zero outputs, then all contents must be re-initialised
      drive(1'b1, 6'd20, 32'hCAFEF00D, 1'b1, 6'd0, 6'd0);
      step();
      drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd20, 6'd20);
      step();
      chk("pre_reset_value", {rg1_a, rd1_a}, 33'h1_CAFEF00D);
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         drive(1'b0, 6'd0, 32'h0, 1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
         step();
      end
      drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd20, 6'd5);
      step();
      chk("run_reset_a20", {rg1_a, rd1_a}, 33'h0);
      chk("run_reset_b5", {rg2_b, rd2_b}, 33'h0);

      // Reset pulsed mid-clear restarts the full clear
      do_reset();
      for (int k = 0; k < 30; k++) step();
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd20, 6'd12);
         step();
         if (k == DEPTH - 2) chk("reclear_ready_63", ready_b, 1'b0);
         if (k == DEPTH - 1) chk("reclear_ready_64", ready_b, 1'b1);
      end
      drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd12, 6'd0);
      step();
      chk("reclear_a12", {rg1_b, rd1_b}, 33'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
